// File: rtl/mem_arbiter.sv
// Single-port main-memory arbiter: write-through first, round-robin between I/D refills.
// Optional watchdog abort is compiled in with `define ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int ADDR_WIDTH       = 32,
  parameter int DATA_WIDTH       = 32,
  parameter int CACHE_LINE_WIDTH = 256,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_ic_read_req,
  input  logic [ADDR_WIDTH-1:0]       i_ic_read_address,
  output logic                        o_ic_read_done,
  output logic [CACHE_LINE_WIDTH-1:0] o_ic_cache_line,
  input  logic                        i_dc_read_req,
  input  logic [ADDR_WIDTH-1:0]       i_dc_read_address,
  output logic                        o_dc_read_done,
  output logic [CACHE_LINE_WIDTH-1:0] o_dc_cache_line,
  input  logic                        i_dc_write_valid,
  input  logic [ADDR_WIDTH-1:0]       i_dc_write_address,
  input  logic [DATA_WIDTH-1:0]       i_dc_write_data,
  input  logic [7:0]                  i_dc_write_strobe,
  output logic                        o_dc_write_done,
  output logic                        o_mem_read_req,
  output logic [ADDR_WIDTH-1:0]       o_mem_read_address,
  input  logic                        i_mem_read_done,
  input  logic [CACHE_LINE_WIDTH-1:0] i_cache_line,
  output logic                        o_mem_write_valid,
  output logic [ADDR_WIDTH-1:0]       o_mem_write_address,
  output logic [DATA_WIDTH-1:0]       o_mem_write_data,
  output logic [7:0]                  o_mem_write_strobe,
  input  logic                        i_mem_write_done,
  output logic                        o_err
);

  typedef enum logic [2:0] {IDLE, RD_IC, RD_DC, WR, RESP} state_e;
  typedef enum logic [1:0] {OWN_IC, OWN_DC, OWN_WR} owner_e;

  if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_e                      state_q, state_d;
  owner_e                      owner_q;
  logic                        last_ic_q;
  logic [ADDR_WIDTH-1:0]       addr_q;
  logic [DATA_WIDTH-1:0]       data_q;
  logic [7:0]                  strobe_q;
  logic [CACHE_LINE_WIDTH-1:0] line_q;

  logic busy, rd_done, wr_done, mem_done, timeout, resp;

  assign busy     = (state_q == RD_IC) || (state_q == RD_DC) || (state_q == WR);
  // Done strobes on the channel not currently in use are dropped here.
  assign rd_done  = i_mem_read_done  && ((state_q == RD_IC) || (state_q == RD_DC));
  assign wr_done  = i_mem_write_done && (state_q == WR);
  assign mem_done = rd_done || wr_done;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  cnt_q <= '0;
    else if (busy) cnt_q <= cnt_q + 1'b1;
    else           cnt_q <= '0;
  end

  assign timeout = busy && !mem_done && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign o_err   = timeout;
`else
  assign timeout = 1'b0;
  assign o_err   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (i_dc_write_valid)                   state_d = WR;
        else if (i_ic_read_req && i_dc_read_req) state_d = last_ic_q ? RD_DC : RD_IC;
        else if (i_ic_read_req)                  state_d = RD_IC;
        else if (i_dc_read_req)                  state_d = RD_DC;
      end
      RD_IC, RD_DC: if (i_mem_read_done || timeout)  state_d = RESP;
      WR:           if (i_mem_write_done || timeout) state_d = RESP;
      RESP:         state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      owner_q   <= OWN_IC;
      last_ic_q <= 1'b1;
      addr_q    <= '0;
      data_q    <= '0;
      strobe_q  <= '0;
      line_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        unique case (state_d)
          RD_IC: begin
            addr_q    <= i_ic_read_address;
            owner_q   <= OWN_IC;
            last_ic_q <= 1'b1;
          end
          RD_DC: begin
            addr_q    <= i_dc_read_address;
            owner_q   <= OWN_DC;
            last_ic_q <= 1'b0;
          end
          WR: begin
            addr_q   <= i_dc_write_address;
            data_q   <= i_dc_write_data;
            strobe_q <= i_dc_write_strobe;
            owner_q  <= OWN_WR;
          end
          default: ;
        endcase
      end
      if (timeout)      line_q <= '0;
      else if (rd_done) line_q <= i_cache_line;
    end
  end

  assign resp = (state_q == RESP);

  assign o_mem_read_req      = (state_q == RD_IC) || (state_q == RD_DC);
  assign o_mem_read_address  = addr_q;
  assign o_mem_write_valid   = (state_q == WR);
  assign o_mem_write_address = addr_q;
  assign o_mem_write_data    = data_q;
  assign o_mem_write_strobe  = strobe_q;

  assign o_ic_read_done  = resp && (owner_q == OWN_IC);
  assign o_dc_read_done  = resp && (owner_q == OWN_DC);
  assign o_dc_write_done = resp && (owner_q == OWN_WR);
  assign o_ic_cache_line = o_ic_read_done ? line_q : '0;
  assign o_dc_cache_line = o_dc_read_done ? line_q : '0;

endmodule
